// File: rtl/enc_op_fc_pkg.sv
// Shared JX2 definitions for the FC/FD op encoder: kind codes, opcode bytes and W0 prefixes.
package enc_op_fc_pkg;

  typedef enum logic [2:0] {
    KIND_STORE  = 3'd0,
    KIND_LOAD   = 3'd1,
    KIND_ALU3I  = 3'd2,
    KIND_CMPI   = 3'd3,
    KIND_BRA    = 3'd4,
    KIND_LDIDLR = 3'd5,
    KIND_PCREL  = 3'd6,
    KIND_LDIR   = 3'd7
  } opKind_e;

  localparam logic [7:0] PFX_FC    = 8'hFC;
  localparam logic [7:0] LOAD_OPC  = 8'h08;
  localparam logic [3:0] ALU3I_OPC = 4'h1;
  localparam logic [7:0] CMPI_OPC  = 8'h19;
  localparam logic [7:0] BRA_LO    = 8'h20;
  localparam logic [7:0] LDIDLR_LO = 8'h24;
  localparam logic [7:0] PCREL_LO  = 8'h27;
  localparam logic [3:0] LDIR_HI   = 4'hF;

  // W0 shared by the memory / immediate-ALU group: 0xFC0e with e = {Q,N4,M4,I}.
  function automatic logic [15:0] memW0(input logic q, input logic n4, input logic m4, input logic i);
    return {PFX_FC, 4'h0, q, n4, m4, i};
  endfunction

  function automatic logic alu3iSubOk(input logic [3:0] sub);
    case (sub)
      4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic cmpiSubOk(input logic [3:0] sub);
    case (sub)
      4'h4, 4'hC, 4'hD, 4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/enc_op_fc_if.sv
// Request and halfword-output channels of the FC/FD op encoder.
interface enc_op_fc_if;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqKind;
  logic [3:0]  reqSub;
  logic        reqQ;
  logic [5:0]  reqRegN;
  logic [5:0]  reqRegM;
  logic [32:0] reqImm;
  logic        outValid;
  logic        outReady;
  logic [15:0] outWord;
  logic        outLast;
  logic        errPulse;
  logic        busy;

  modport master (
    output reqValid, reqKind, reqSub, reqQ, reqRegN, reqRegM, reqImm, outReady,
    input  reqReady, outValid, outWord, outLast, errPulse, busy
  );

  modport slave (
    input  reqValid, reqKind, reqSub, reqQ, reqRegN, reqRegM, reqImm, outReady,
    output reqReady, outValid, outWord, outLast, errPulse, busy
  );
endinterface

// File: rtl/enc_op_fc_pack.sv
// Combinational packer: request fields -> {W0,W1,W2} plus a reject flag.
module enc_op_fc_pack import enc_op_fc_pkg::*; #(
  parameter int REJECT_RANGE = 1
) (
  input  logic [2:0]  kind,
  input  logic [3:0]  sub,
  input  logic        q,
  input  logic [5:0]  regN,
  input  logic [5:0]  regM,
  input  logic [32:0] imm,
  output logic [47:0] word,
  output logic        err
);

  localparam logic RANGE_EN = 1'(REJECT_RANGE != 0);

  logic [15:0] w0S, w1S, w2S;
  logic        illegalS, outOfRangeS;
  logic        fitsS17S, fitsU17S, fitsS24S;

  assign fitsS17S = (imm[32:16] == {17{imm[16]}});
  assign fitsU17S = (imm[32:17] == 16'h0000);
  assign fitsS24S = (imm[32:23] == {10{imm[23]}});

  // Per-kind field placement and legality; unused kinds of checks stay at their defaults.
  always_comb begin
    w0S = 16'h0000;
    w1S = 16'h0000;
    w2S = imm[15:0];
    illegalS = 1'b0;
    outOfRangeS = 1'b0;
    case (kind)
      KIND_STORE: begin
        w0S = memW0(q, regN[4], regM[4], imm[16]);
        w1S = {6'b000000, sub[1:0], regN[3:0], regM[3:0]};
        illegalS = (sub[3:2] != 2'b00);
        outOfRangeS = !fitsS17S;
      end
      KIND_LOAD: begin
        w0S = memW0(sub[2], regN[4], regM[4], imm[16]);
        w1S = {LOAD_OPC + {6'b000000, sub[1:0]}, regN[3:0], regM[3:0]};
        illegalS = sub[3];
        outOfRangeS = !fitsS17S;
      end
      KIND_ALU3I: begin
        w0S = memW0(1'b0, regN[4], regM[4], imm[16]);
        w1S = {ALU3I_OPC, sub, regN[3:0], regM[3:0]};
        illegalS = !alu3iSubOk(sub);
        // sub 0/1 take a zero-extended immediate, the rest sign-extended
        outOfRangeS = (sub[3:1] == 3'b000) ? !fitsU17S : !fitsS17S;
      end
      KIND_CMPI: begin
        w0S = memW0(q, regN[4], 1'b0, imm[16]);
        w1S = {CMPI_OPC, regN[3:0], sub};
        illegalS = !cmpiSubOk(sub);
        outOfRangeS = !fitsS17S;
      end
      KIND_BRA: begin
        w0S = {PFX_FC, BRA_LO + {6'b000000, sub[1:0]}};
        w1S = imm[15:0];
        w2S = imm[31:16];
        illegalS = (sub[3:2] != 2'b00);
        outOfRangeS = (imm[32] != imm[31]);
      end
      KIND_LDIDLR: begin
        w0S = {PFX_FC, LDIDLR_LO + {6'b000000, sub[1:0]}};
        w1S = imm[15:0];
        w2S = imm[31:16];
        illegalS = (sub > 4'd2);
      end
      KIND_PCREL: begin
        w0S = {PFX_FC[7:1], regN[4], PCREL_LO};
        w1S = {sub, regN[3:0], imm[23:16]};
        illegalS = (sub == 4'd5) || (sub == 4'd6) || (sub == 4'd7);
        outOfRangeS = !fitsS24S;
      end
      KIND_LDIR: begin
        w0S = {LDIR_HI, 3'b110, regN[4], 2'b11, sub[1:0], regN[3:0]};
        w1S = imm[15:0];
        w2S = imm[31:16];
        illegalS = (sub[3:2] != 2'b00);
      end
      default: begin
        illegalS = 1'b1;
      end
    endcase
  end

  assign word = {w0S, w1S, w2S};
  assign err  = illegalS | regN[5] | regM[5] | (RANGE_EN & outOfRangeS);

endmodule

// File: rtl/enc_op_fc.sv
// FC/FD op encoder: accepts one request and streams its three halfwords W0,W1,W2.
// A request can be taken during the final beat, so ops stream back to back.
module enc_op_fc #(
  parameter int REJECT_RANGE = 1
) (
  input logic        clock,
  input logic        reset,
  enc_op_fc_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_W0   = 2'd1;
  localparam logic [1:0] ST_W1   = 2'd2;
  localparam logic [1:0] ST_W2   = 2'd3;

  logic [1:0]  stateR, stateS;
  logic [47:0] encR, encS, packWordS;
  logic        packErrS;
  logic        outValidR, outValidS;
  logic [15:0] outWordR, outWordS;
  logic        outLastR, outLastS;
  logic        errPulseR, errPulseS;
  logic        busyR;
  logic        reqReadyS, acceptS;

  enc_op_fc_pack #(.REJECT_RANGE(REJECT_RANGE)) uPack (
    .kind (bus.reqKind),
    .sub  (bus.reqSub),
    .q    (bus.reqQ),
    .regN (bus.reqRegN),
    .regM (bus.reqRegM),
    .imm  (bus.reqImm),
    .word (packWordS),
    .err  (packErrS)
  );

  assign reqReadyS = (stateR == ST_IDLE) || ((stateR == ST_W2) && bus.outReady);
  assign acceptS   = bus.reqValid && reqReadyS;

  // Next state: a good accept loads a fresh op, otherwise each taken beat advances.
  always_comb begin
    stateS    = stateR;
    encS      = encR;
    outValidS = outValidR;
    outWordS  = outWordR;
    outLastS  = outLastR;
    errPulseS = acceptS && packErrS;
    if (acceptS && !packErrS) begin
      stateS    = ST_W0;
      encS      = packWordS;
      outValidS = 1'b1;
      outWordS  = packWordS[47:32];
      outLastS  = 1'b0;
    end else begin
      case (stateR)
        ST_IDLE: begin
          outValidS = 1'b0;
        end
        ST_W0: begin
          if (bus.outReady) begin
            stateS   = ST_W1;
            outWordS = encR[31:16];
          end else begin
            stateS = ST_W0;
          end
        end
        ST_W1: begin
          if (bus.outReady) begin
            stateS   = ST_W2;
            outWordS = encR[15:0];
            outLastS = 1'b1;
          end else begin
            stateS = ST_W1;
          end
        end
        ST_W2: begin
          if (bus.outReady) begin
            stateS    = ST_IDLE;
            outValidS = 1'b0;
            outLastS  = 1'b0;
          end else begin
            stateS = ST_W2;
          end
        end
        default: begin
          stateS    = ST_IDLE;
          outValidS = 1'b0;
          outLastS  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset drops any op in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateR    <= ST_IDLE;
      encR      <= 48'h0000_0000_0000;
      outValidR <= 1'b0;
      outWordR  <= 16'h0000;
      outLastR  <= 1'b0;
      errPulseR <= 1'b0;
      busyR     <= 1'b0;
    end else begin
      stateR    <= stateS;
      encR      <= encS;
      outValidR <= outValidS;
      outWordR  <= outWordS;
      outLastR  <= outLastS;
      errPulseR <= errPulseS;
      busyR     <= (stateS != ST_IDLE);
    end
  end

  assign bus.reqReady = reqReadyS;
  assign bus.outValid = outValidR;
  assign bus.outWord  = outWordR;
  assign bus.outLast  = outLastR;
  assign bus.errPulse = errPulseR;
  assign bus.busy     = busyR;

endmodule

// File: tb/tb_enc_op_fc.sv
// Bench for enc_op_fc: fixed vectors, handshake corner sequences and a randomized run vs a reference model.
module tb_enc_op_fc;

  logic clock;
  logic reset;
  enc_op_fc_if bif();

  enc_op_fc dut (.clock(clock), .reset(reset), .bus(bif));

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  kind;
    logic [3:0]  sub;
    logic        q;
    logic [5:0]  n;
    logic [5:0]  m;
    logic [32:0] imm;
    logic        err;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
  } vec_t;

  vec_t        tv[16];
  int          total = 0;
  int          bad = 0;
  logic [16:0] expQ[$];
  logic        curErr;
  logic [15:0] curW0, curW1, curW2;
  logic        lastAcc;
  logic        holdValid = 1'b0;
  logic [15:0] holdWord;
  logic        holdLast;
  int          cyc = 0;
  int          beatCnt = 0;
  int          firstBeat = 0;
  int          lastBeat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: field placement from the op format, ranges as plain signed-integer bounds.
  function automatic void refModel(input logic [2:0] k, input logic [3:0] s, input logic q,
      input logic [5:0] n, input logic [5:0] m, input logic [32:0] imm,
      output logic err, output logic [15:0] w0, output logic [15:0] w1, output logic [15:0] w2);
    longint u, v;
    int sb, rn, rm, n4, m4, lo, hi, ib, qb;
    bit ill, oor;
    u = longint'({31'd0, imm});
    v = (u >= 64'sh1_0000_0000) ? u - 64'sh2_0000_0000 : u;
    sb = int'(s); rn = int'(n); rm = int'(m); qb = int'(q);
    n4 = (rn / 16) % 2; m4 = (rm / 16) % 2;
    lo = int'(u % 65536); hi = int'((u / 65536) % 65536); ib = hi % 2;
    ill = (rn >= 32) || (rm >= 32);
    oor = 1'b0;
    w0 = 16'h0000; w1 = 16'h0000; w2 = 16'(lo);
    case (k)
      3'd0: begin
        ill |= (sb > 3);
        w0 = 16'(32'hFC00 + qb * 8 + n4 * 4 + m4 * 2 + ib);
        w1 = 16'(sb * 256 + (rn % 16) * 16 + rm % 16);
        oor = (v < -65536) || (v > 65535);
      end
      3'd1: begin
        ill |= (sb >= 8);
        qb = (sb / 4) % 2;
        w0 = 16'(32'hFC00 + qb * 8 + n4 * 4 + m4 * 2 + ib);
        w1 = 16'((8 + sb % 4) * 256 + (rn % 16) * 16 + rm % 16);
        oor = (v < -65536) || (v > 65535);
      end
      3'd2: begin
        ill |= !(sb inside {0, 1, 2, 5, 6, 7});
        w0 = 16'(32'hFC00 + n4 * 4 + m4 * 2 + ib);
        w1 = 16'((16 + sb) * 256 + (rn % 16) * 16 + rm % 16);
        oor = (sb < 2) ? ((v < 0) || (v >= 131072)) : ((v < -65536) || (v > 65535));
      end
      3'd3: begin
        ill |= !(sb inside {4, 12, 13, 14});
        w0 = 16'(32'hFC00 + qb * 8 + n4 * 4 + ib);
        w1 = 16'(32'h19 * 256 + (rn % 16) * 16 + sb);
        oor = (v < -65536) || (v > 65535);
      end
      3'd4: begin
        ill |= (sb > 3);
        w0 = 16'(32'hFC20 + sb); w1 = 16'(lo); w2 = 16'(hi);
        oor = (v < -64'sh8000_0000) || (v >= 64'sh8000_0000);
      end
      3'd5: begin
        ill |= (sb > 2);
        w0 = 16'(32'hFC24 + sb); w1 = 16'(lo); w2 = 16'(hi);
      end
      3'd6: begin
        ill |= (sb inside {5, 6, 7});
        w0 = 16'(32'hFC27 + n4 * 256);
        w1 = 16'(sb * 4096 + (rn % 16) * 256 + hi % 256);
        oor = (v < -8388608) || (v >= 8388608);
      end
      default: begin
        ill |= (sb > 3);
        w0 = 16'(32'hFC00 + n4 * 256 + (12 + sb) * 16 + rn % 16);
        w1 = 16'(lo); w2 = 16'(hi);
      end
    endcase
    err = ill || oor;
  endfunction

  // One clock: check the beat about to be taken, book the accept, then check post-edge status.
  task automatic tick();
    logic acc, beat, expErr;
    logic [16:0] e;
    #1;
    acc  = bif.reqValid && bif.reqReady;
    beat = bif.outValid && bif.outReady;
    if (holdValid && bif.outValid) begin
      check("hold_word", 32'(bif.outWord), 32'(holdWord));
      check("hold_last", 32'(bif.outLast), 32'(holdLast));
    end
    holdValid = bif.outValid && !bif.outReady;
    holdWord  = bif.outWord;
    holdLast  = bif.outLast;
    if (beat) begin
      beatCnt++;
      if (beatCnt == 1) firstBeat = cyc;
      lastBeat = cyc;
      if (expQ.size() == 0) begin
        check("spurious_beat", 32'(bif.outWord), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        check("beat_word", 32'(bif.outWord), 32'(e[15:0]));
        check("beat_last", 32'(bif.outLast), 32'(e[16]));
      end
    end
    expErr = acc && curErr;
    if (acc && !curErr) begin
      expQ.push_back({1'b0, curW0});
      expQ.push_back({1'b0, curW1});
      expQ.push_back({1'b1, curW2});
    end
    lastAcc = acc;
    @(negedge clock);
    cyc++;
    check("errPulse", 32'(bif.errPulse), 32'(expErr));
    check("busy", 32'(bif.busy), 32'(expQ.size() != 0));
    check("outValid", 32'(bif.outValid), 32'(expQ.size() != 0));
  endtask

  task automatic setVec(input vec_t v);
    bif.reqKind = v.kind; bif.reqSub = v.sub; bif.reqQ = v.q;
    bif.reqRegN = v.n; bif.reqRegM = v.m; bif.reqImm = v.imm;
    curErr = v.err; curW0 = v.w0; curW1 = v.w1; curW2 = v.w2;
  endtask

  task automatic drain();
    bif.reqValid = 1'b0;
    bif.outReady = 1'b1;
    for (int i = 0; i < 30 && expQ.size() != 0; i++) tick();
    check("drain_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic randReq();
    logic [32:0] imm;
    logic [31:0] r;
    logic [31:0] b;
    logic [3:0]  s;
    logic [5:0]  n, m;
    logic [2:0]  k;
    k = 3'($urandom_range(0, 7));
    s = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    n = 6'($urandom_range(0, 31));
    m = 6'($urandom_range(0, 31));
    if ($urandom_range(0, 15) == 0) n[5] = 1'b1;
    if ($urandom_range(0, 15) == 0) m[5] = 1'b1;
    r = $urandom();
    b = $urandom_range(0, 1);
    case ($urandom_range(0, 4))
      0: imm = 33'($urandom_range(0, 1000));
      1: imm = 33'h0 - 33'($urandom_range(1, 1000));
      2: imm = {b[0], r};
      default: begin
        case ($urandom_range(0, 13))
          0: imm = 33'h0_0000_FFFF;  1: imm = 33'h0_0001_0000;
          2: imm = 33'h1_FFFF_0000;  3: imm = 33'h1_FFFE_FFFF;
          4: imm = 33'h0_0001_FFFF;  5: imm = 33'h0_0002_0000;
          6: imm = 33'h0_007F_FFFF;  7: imm = 33'h0_0080_0000;
          8: imm = 33'h1_FF80_0000;  9: imm = 33'h1_FF7F_FFFF;
          10: imm = 33'h0_7FFF_FFFF; 11: imm = 33'h0_8000_0000;
          12: imm = 33'h1_8000_0000; default: imm = 33'h1_7FFF_FFFF;
        endcase
      end
    endcase
    bif.reqKind = k; bif.reqSub = s; bif.reqQ = 1'($urandom_range(0, 1));
    bif.reqRegN = n; bif.reqRegM = m; bif.reqImm = imm;
    refModel(k, s, bif.reqQ, n, m, imm, curErr, curW0, curW1, curW2);
  endtask

  initial begin
    tv[0]  = '{3'd1, 4'd6,  1'b0, 6'd5,  6'd17, 33'h0_0000_0010, 1'b0, 16'hFC0A, 16'h0A51, 16'h0010};
    tv[1]  = '{3'd7, 4'd0,  1'b0, 6'd20, 6'd0,  33'h0_1234_5678, 1'b0, 16'hFDC4, 16'h5678, 16'h1234};
    tv[2]  = '{3'd4, 4'd1,  1'b0, 6'd0,  6'd0,  33'h1_FFFF_FFFC, 1'b0, 16'hFC21, 16'hFFFC, 16'hFFFF};
    tv[3]  = '{3'd2, 4'd0,  1'b0, 6'd0,  6'd0,  33'h0_0002_0000, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    tv[4]  = '{3'd0, 4'd2,  1'b1, 6'd3,  6'd18, 33'h1_FFFF_8000, 1'b0, 16'hFC0B, 16'h0232, 16'h8000};
    tv[5]  = '{3'd3, 4'hC,  1'b1, 6'd21, 6'd7,  33'h0_0000_1234, 1'b0, 16'hFC0C, 16'h195C, 16'h1234};
    tv[6]  = '{3'd6, 4'd3,  1'b0, 6'd17, 6'd0,  33'h0_007F_ABCD, 1'b0, 16'hFD27, 16'h317F, 16'hABCD};
    tv[7]  = '{3'd6, 4'd3,  1'b0, 6'd17, 6'd0,  33'h0_0080_0000, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    tv[8]  = '{3'd5, 4'd2,  1'b0, 6'd0,  6'd0,  33'h1_0000_0005, 1'b0, 16'hFC26, 16'h0005, 16'h0000};
    tv[9]  = '{3'd5, 4'd3,  1'b0, 6'd0,  6'd0,  33'h0_0000_0005, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    tv[10] = '{3'd2, 4'd5,  1'b0, 6'd2,  6'd3,  33'h1_FFFF_FFFF, 1'b0, 16'hFC01, 16'h1523, 16'hFFFF};
    tv[11] = '{3'd2, 4'd1,  1'b0, 6'd0,  6'd0,  33'h0_0001_FFFF, 1'b0, 16'hFC01, 16'h1100, 16'hFFFF};
    tv[12] = '{3'd0, 4'd0,  1'b0, 6'd32, 6'd0,  33'h0_0000_0000, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    tv[13] = '{3'd4, 4'd0,  1'b0, 6'd0,  6'd0,  33'h0_8000_0000, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    tv[14] = '{3'd3, 4'd5,  1'b0, 6'd0,  6'd0,  33'h0_0000_0001, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    tv[15] = '{3'd1, 4'd8,  1'b0, 6'd0,  6'd0,  33'h0_0000_0001, 1'b1, 16'h0000, 16'h0000, 16'h0000};

    clock = 1'b0;
    reset = 1'b0;
    bif.reqValid = 1'b0; bif.outReady = 1'b0;
    setVec(tv[0]);
    #12;
    check("rst_outValid", 32'(bif.outValid), 32'd0);
    check("rst_outWord", 32'(bif.outWord), 32'd0);
    check("rst_outLast", 32'(bif.outLast), 32'd0);
    check("rst_errPulse", 32'(bif.errPulse), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_reqReady", 32'(bif.reqReady), 32'd1);

    // Fixed vectors, one op at a time from idle.
    for (int i = 0; i < 16; i++) begin
      setVec(tv[i]);
      bif.reqValid = 1'b1;
      bif.outReady = 1'b1;
      tick();
      check("vec_accept", 32'(lastAcc), 32'd1);
      drain();
    end

    // Back-pressure in W1, then two back-to-back ops.
    setVec(tv[0]);
    bif.reqValid = 1'b1; bif.outReady = 1'b1;
    tick();
    bif.reqValid = 1'b0;
    tick();
    bif.outReady = 1'b0;
    repeat (3) tick();
    drain();
    beatCnt = 0;
    setVec(tv[1]);
    bif.reqValid = 1'b1;
    tick();
    setVec(tv[2]);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (lastAcc) break;
    end
    check("b2b_accept", 32'(lastAcc), 32'd1);
    drain();
    check("b2b_beats", 32'(beatCnt), 32'd6);
    check("b2b_span", 32'(lastBeat - firstBeat), 32'd5);

    // Reset while in W1: beats vanish at once, next op restarts at W0.
    setVec(tv[4]);
    bif.reqValid = 1'b1; bif.outReady = 1'b1;
    tick();
    bif.reqValid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_outValid", 32'(bif.outValid), 32'd0);
    check("midrst_busy", 32'(bif.busy), 32'd0);
    check("midrst_outWord", 32'(bif.outWord), 32'd0);
    expQ.delete();
    holdValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_reqReady", 32'(bif.reqReady), 32'd1);
    setVec(tv[2]);
    bif.reqValid = 1'b1;
    tick();
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      randReq();
      bif.reqValid = ($urandom_range(0, 9) < 7);
      bif.outReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
